// File: rtl/cache_req_ctrl.sv
// cache_req_ctrl: single-outstanding request sequencer in front of a
// direct-mapped L1 (14-bit index, 18-bit tag). Lookup -> optional memory
// fetch with timeout -> one-cycle fill -> response.
// Optional macro CACHE_STATS_EN adds saturating hit/miss counters; when the
// macro is undefined the counter outputs are tied to zero.
module cache_req_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_hit,
  output logic              resp_err,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_we,
  output logic              cache_oe,
  input  logic              cache_found,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] MEM_REQ = 3'd2;
  localparam logic [2:0] FILL    = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  // Counter only has to reach MEM_TIMEOUT-1.
  localparam int            TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit            TO_EN   = (MEM_TIMEOUT != 0);

  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [TO_W-1:0]   to_cnt;
  logic              hit_q, err_q;
  logic              to_hit;

  assign to_hit = TO_EN && (to_cnt == TO_LAST);

  // Next-state decode; mem_ack beats a same-cycle timeout.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = cache_found ? RESP : MEM_REQ;
      MEM_REQ: begin
        if (mem_ack)     state_d = FILL;
        else if (to_hit) state_d = RESP;
      end
      FILL:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched address, timeout counter and response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      to_cnt <= '0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && req_valid) addr_q <= req_addr;
      // Held at zero outside MEM_REQ, so it is clear on every entry.
      to_cnt <= (state == MEM_REQ) ? to_cnt + 1'b1 : '0;
      if (state == LOOKUP) begin
        hit_q <= cache_found;
        err_q <= 1'b0;
      end
      if (state == MEM_REQ && !mem_ack && to_hit) err_q <= 1'b1;
    end
  end

  // Outputs decode straight from state so reset drops them asynchronously.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_addr  = (state == RESP) ? addr_q : '0;
  assign resp_hit   = (state == RESP) && hit_q;
  assign resp_err   = (state == RESP) && err_q;
  assign cache_oe   = (state == LOOKUP);
  assign cache_we   = (state == FILL);
  assign cache_addr = (state == LOOKUP || state == FILL) ? addr_q : '0;
  assign mem_req    = (state == MEM_REQ);
  assign mem_addr   = (state == MEM_REQ) ? addr_q : '0;

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] hit_q_cnt, miss_q_cnt;

  // Saturating lookup outcome counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q_cnt  <= '0;
      miss_q_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (cache_found && hit_q_cnt != '1)   hit_q_cnt  <= hit_q_cnt + 1'b1;
      if (!cache_found && miss_q_cnt != '1) miss_q_cnt <= miss_q_cnt + 1'b1;
    end
  end

  assign hit_count  = hit_q_cnt;
  assign miss_count = miss_q_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl, built with MEM_TIMEOUT=4.
module tb_cache_req_ctrl;
  localparam int AW = 32;
  localparam int CW = 16;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, resp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready, resp_valid, resp_hit, resp_err;
  logic [AW-1:0] resp_addr, cache_addr, mem_addr;
  logic          cache_we, cache_oe, mem_req;
  logic          cache_found = 1'b0, mem_ack = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  int checks = 0, errors = 0;
  int we_cnt = 0;
  logic [AW-1:0] we_addr = '0;
  bit both_seen = 1'b0;

  cache_req_ctrl #(.ADDR_W(AW), .MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_hit(resp_hit),
    .resp_err(resp_err), .resp_ready(resp_ready),
    .cache_addr(cache_addr), .cache_we(cache_we), .cache_oe(cache_oe),
    .cache_found(cache_found),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Fill-strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (cache_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= cache_addr;
    end
    if (cache_we && cache_oe) both_seen <= 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one request; returns #1 after the accepting edge (cycle 1).
  task automatic do_req(input logic [AW-1:0] a);
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
  endtask

  // Run one transaction up to resp_valid; ack_at = mem_req cycle that acks (0 = never).
  task automatic run_txn(input logic [AW-1:0] a, input logic found, input int ack_at,
                         output int lat, output int mcnt, output bit bad_addr);
    cache_found = found;
    mcnt = 0; bad_addr = 1'b0;
    do_req(a);
    lat = 1;
    if (!cache_oe || cache_addr !== a) bad_addr = 1'b1;
    while (!resp_valid && lat < 40) begin
      if (mem_req) begin
        mcnt++;
        if (mem_addr !== a) bad_addr = 1'b1;
        mem_ack = (ack_at != 0 && mcnt == ack_at);
      end
      tick();
      mem_ack = 1'b0;
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int we0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req !== 1'b0 ||
                  cache_we !== 1'b0 || cache_oe !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: rdy=%b rv=%b mreq=%b we=%b oe=%b, want 1 0 0 0 0",
                         req_ready, resp_valid, mem_req, cache_we, cache_oe); end
    checks++; if (hit_count !== '0 || miss_count !== '0) begin
      errors++; $display("FAIL reset_counters: hit=%0d miss=%0d, want 0 0", hit_count, miss_count); end
    @(negedge clk); rst = 1'b0;
    tick();
    // Reset while waiting in MEM_REQ.
    cache_found = 1'b0;
    we0 = we_cnt;
    do_req(32'h0000_1234);
    tick(); tick();
    checks++; if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_mid_premise: mem_req=%b, want 1", mem_req); end
    #2 rst = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: mreq=%b rdy=%b rv=%b, want 0 1 0",
                         mem_req, req_ready, resp_valid); end
    tick(); tick();
    checks++; if (we_cnt !== we0) begin
      errors++; $display("FAIL rst_mid_nofill: fills=%0d, want %0d", we_cnt, we0); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    int lat, mc, we0; bit bad;
    we0 = we_cnt;
    run_txn(32'hABCD_0010, 1'b0, 3, lat, mc, bad);
    checks++; if (lat !== 6 || mc !== 3) begin
      errors++; $display("FAIL miss_latency: lat=%0d memcyc=%0d, want 6 3", lat, mc); end
    checks++; if (resp_hit !== 1'b0 || resp_err !== 1'b0 || resp_addr !== 32'hABCD_0010) begin
      errors++; $display("FAIL miss_resp: hit=%b err=%b addr=%h, want 0 0 abcd0010",
                         resp_hit, resp_err, resp_addr); end
    checks++; if (we_cnt - we0 !== 1 || we_addr !== 32'hABCD_0010 || bad) begin
      errors++; $display("FAIL miss_fill: fills=%0d addr=%h badaddr=%b, want 1 abcd0010 0",
                         we_cnt - we0, we_addr, bad); end
    consume();
  endtask

  task automatic test_hit();
    int lat, mc, we0; bit bad;
    we0 = we_cnt;
    run_txn(32'hABCD_0010, 1'b1, 0, lat, mc, bad);
    checks++; if (lat !== 2 || mc !== 0 || we_cnt !== we0 || bad) begin
      errors++; $display("FAIL hit_path: lat=%0d memcyc=%0d fills=%0d bad=%b, want 2 0 0 0",
                         lat, mc, we_cnt - we0, bad); end
    checks++; if (resp_hit !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL hit_resp: hit=%b err=%b, want 1 0", resp_hit, resp_err); end
    checks++; if (hit_count !== (STATS ? 16'd1 : 16'd0) || miss_count !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL hit_stats: hit=%0d miss=%0d, want %0d %0d",
                         hit_count, miss_count, STATS, STATS); end
    consume();
  endtask

  task automatic test_conflict();
    int lat, mc, we0; bit bad;
    we0 = we_cnt;
    run_txn(32'h1234_0010, 1'b0, 1, lat, mc, bad);
    checks++; if (lat !== 4 || resp_hit !== 1'b0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL conflict_resp: lat=%0d hit=%b err=%b, want 4 0 0",
                         lat, resp_hit, resp_err); end
    checks++; if (we_cnt - we0 !== 1 || we_addr !== 32'h1234_0010 || bad) begin
      errors++; $display("FAIL conflict_fill: fills=%0d addr=%h bad=%b, want 1 12340010 0",
                         we_cnt - we0, we_addr, bad); end
    consume();
  endtask

  task automatic test_timeout();
    int lat, mc, we0; bit bad;
    we0 = we_cnt;
    run_txn(32'h5555_0040, 1'b0, 0, lat, mc, bad);
    checks++; if (mc !== 4 || lat !== 6) begin
      errors++; $display("FAIL timeout_len: memcyc=%0d lat=%0d, want 4 6", mc, lat); end
    checks++; if (resp_err !== 1'b1 || resp_hit !== 1'b0 || we_cnt !== we0) begin
      errors++; $display("FAIL timeout_resp: err=%b hit=%b fills=%0d, want 1 0 0",
                         resp_err, resp_hit, we_cnt - we0); end
    checks++; if (miss_count !== (STATS ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL timeout_stats: miss=%0d, want %0d", miss_count, STATS ? 3 : 0); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, mc, bad_cyc = 0, extra = 0; bit bad;
    run_txn(32'h0BAD_0100, 1'b1, 0, lat, mc, bad);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin req_valid = 1'b1; req_addr = 32'hDEAD_0000; mem_ack = 1'b1; end
      if (resp_valid !== 1'b1 || resp_addr !== 32'h0BAD_0100 || resp_hit !== 1'b1 ||
          req_ready !== 1'b0) bad_cyc++;
      tick();
      req_valid = 1'b0; mem_ack = 1'b0;
    end
    checks++; if (bad_cyc !== 0) begin
      errors++; $display("FAIL bp_stable: unstable cycles=%0d, want 0", bad_cyc); end
    consume();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: rv=%b rdy=%b, want 0 1", resp_valid, req_ready); end
    // Stray mem_ack in IDLE, then confirm no phantom response.
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid || mem_req || cache_oe) extra++;
      tick();
    end
    checks++; if (extra !== 0) begin
      errors++; $display("FAIL bp_single_resp: extra active cycles=%0d, want 0", extra); end
    checks++; if (both_seen !== 1'b0) begin
      errors++; $display("FAIL oe_we_excl: both seen=%b, want 0", both_seen); end
  endtask

  initial begin
    #1;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_req_ctrl.md
Name: cache_req_ctrl

Overview:
- Request sequencer that sits directly upstream of the direct-mapped L1 cache (16384 entries, 14-bit index, 18-bit tag, valid bit).
- Accepts 32-bit address requests over a valid/ready handshake and drives a cache lookup.
- On a miss, fetches from main memory through a req/ack handshake, then issues a one-cycle cache fill.
- Returns a hit/miss/error response to the requester. One request is in flight at a time.

Parameters:
- ADDR_W, 32, request/cache/memory address width.
- MEM_TIMEOUT, 255, cycles to wait for mem_ack before aborting; 0 = wait forever.
- CNT_W, 16, width of statistics counters (CACHE_STATS_EN only).

Ports:
- clk  in  1  rising-edge clock; the cache evaluates lookups on the falling edge of the same clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_addr  in  ADDR_W  requested address.
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  response present.
- resp_addr  out  ADDR_W  address of completed request.
- resp_hit  out  1  1 = cache hit, 0 = miss (filled or aborted).
- resp_err  out  1  1 = memory timeout, no fill performed.
- resp_ready  in  1  requester consumes response.
- cache_addr  out  ADDR_W  address driven to cache ([13:0] index, [31:14] tag).
- cache_we  out  1  cache fill strobe.
- cache_oe  out  1  cache lookup enable.
- cache_found  in  1  cache tag-match result.
- mem_req  out  1  memory fetch request.
- mem_addr  out  ADDR_W  fetch address.
- mem_ack  in  1  memory fetch complete.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- States: IDLE, LOOKUP, MEM_REQ, FILL, RESP.
- Reset (async, any state): state=IDLE; latched addr=0; timeout counter=0. All outputs 0 except req_ready=1. Counters=0. An in-flight mem_req drops immediately; no fill is issued.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge: latch req_addr, go to LOOKUP.
- LOOKUP (1 cycle):
  - cache_oe=1, cache_we=0, cache_addr=latched addr.
  - The cache resolves found at the mid-cycle falling edge; the controller samples cache_found at the closing rising edge.
  - found=1: go to RESP with resp_hit=1.
  - found=0: go to MEM_REQ.
- MEM_REQ:
  - mem_req=1, mem_addr=latched addr, held stable until mem_ack.
  - Timeout counter increments each cycle in this state.
  - mem_ack=1: go to FILL.
  - Otherwise, if MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT-1 with no ack: go to RESP with resp_hit=0, resp_err=1.
  - mem_ack together with the timeout in the same cycle: the ack wins.
- FILL (1 cycle):
  - cache_we=1, cache_oe=0, cache_addr=latched addr.
  - Go to RESP with resp_hit=0, resp_err=0.
- RESP:
  - resp_valid=1; resp_addr/resp_hit/resp_err held stable.
  - On resp_ready: go to IDLE. The next request is accepted no earlier than the following cycle.
- Latency with resp_ready tied high:
  - Hit: resp_valid 2 cycles after acceptance.
  - Miss: 3 + N cycles, where N = cycles until mem_ack.
- cache_oe and cache_we are never both 1.
- cache_oe=0 outside LOOKUP, so the cache's bidirectional data pins stay undriven by the cache.
- mem_ack outside MEM_REQ is ignored.
- req_valid outside IDLE is ignored (req_ready=0).
- The timeout counter clears on entry to MEM_REQ.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - hit_count increments on LOOKUP→RESP.
  - miss_count increments on LOOKUP→MEM_REQ.
  - Both saturate at 2^CNT_W-1 and clear only on rst.
- Undefined: hit_count and miss_count are tied to 0; no counter flops are generated.

Test Plan:
- Reset mid-MEM_REQ (addr 0x0000_1234, no ack): assert rst → mem_req falls asynchronously, req_ready=1, resp_valid=0, no cache_we pulse.
- Cold miss: req 0xABCD_0010, cache_found=0, mem_ack 3 cycles after mem_req → one cache_we pulse with cache_addr=0xABCD_0010; resp_valid with resp_hit=0, resp_err=0 at cycle 6 after acceptance.
- Hit: repeat req 0xABCD_0010 with found=1 → resp_hit=1 at cycle 2; no mem_req; hit_count=1, miss_count=1 (stats on).
- Conflict: req 0x1234_0010 (same index 0x0010, different tag), found=0 → miss path, fill, resp_hit=0.
- Timeout with MEM_TIMEOUT=4 and mem_ack never asserted → mem_req high exactly 4 cycles; resp_err=1, resp_hit=0, no cache_we.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_valid/resp_addr stable; req_ready=0; a req_valid pulse is ignored; exactly one response per accepted request.
